intadd_acc8: RTL

- Downstream stage of the 32-lane three-input saturating 8-bit lane adder.
- Takes that adder's split-nibble outputs (low nibbles, high nibbles) through a valid/ready handshake and rebuilds each 8-bit lane.
- Saturating-accumulates the lanes over a group of beats.
- Drains the 32 accumulated lanes as two packed 128-bit output beats toward writeback.

---
 rtl/intadd_acc8_if.sv | 29 ++
 rtl/intadd_acc8.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/intadd_acc8_if.sv
// Handshake bundle for intadd_acc8: nibble-split input beats in, packed lane beats out.
// The slave modport is the accumulator's view; master is the upstream/downstream side.
interface intadd_acc8_if #(
  parameter int LANES = 32,
  parameter int CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [4*LANES-1:0]   in_lo;
  logic [4*LANES-1:0]   in_hi;
  logic                 in_sign;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*LANES-1:0]   out_data;
  logic                 out_beat;
  logic [CNT_W-1:0]     out_cnt;
  logic [LANES-1:0]     sat_mask;

  modport slave (
    input  in_valid, in_lo, in_hi, in_sign, in_last, out_ready,
    output in_ready, out_valid, out_data, out_beat, out_cnt, sat_mask
  );

  modport master (
    output in_valid, in_lo, in_hi, in_sign, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_beat, out_cnt, sat_mask
  );
endinterface

// File: rtl/intadd_acc8.sv
// Rebuilds 8-bit lanes from split nibbles, saturating-accumulates a group, drains as two beats.
// Define INTADD_ACC8_SAT_STATUS_EN to track per-lane clamps in sat_mask; otherwise it is tied to 0.
module intadd_acc8 #(
  parameter int LANES = 32,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  intadd_acc8_if.slave  bus
);
  localparam int HALF = LANES / 2;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN0, DRAIN1} state_e;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b,
                                         input logic sgn);
    logic [8:0] s;
    if (sgn) begin
      s = {a[7], a} + {b[7], b};
      if (s[8] != s[7]) return s[8] ? 8'h80 : 8'h7F;
    end else begin
      s = {1'b0, a} + {1'b0, b};
      if (s[8]) return 8'hFF;
    end
    return s[7:0];
  endfunction

  state_e                  state_q, state_d;
  logic [LANES-1:0][7:0]   acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sign_q, sign_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_beat_q, out_beat_d;
  logic [8*HALF-1:0]       out_data_q, out_data_d;
  logic [LANES-1:0][7:0]   sum_lane;
  logic                    first_beat;
  logic                    eff_sign;
  logic                    in_ready;
  logic                    accept;

  assign in_ready   = (state_q == IDLE) || (state_q == ACC);
  assign accept     = bus.in_valid && in_ready;
  // The first beat of a group starts from zero and uses the incoming sign; later beats use the latched one.
  assign first_beat = (state_q == IDLE);
  assign eff_sign   = first_beat ? bus.in_sign : sign_q;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sum_lane[i] = sat_add(first_beat ? 8'h00 : acc_q[i],
                            {bus.in_hi[4*i +: 4], bus.in_lo[4*i +: 4]}, eff_sign);
    end
  end

`ifdef INTADD_ACC8_SAT_STATUS_EN
  function automatic logic sat_hit(input logic [7:0] a, input logic [7:0] b, input logic sgn);
    logic [8:0] s;
    if (sgn) begin
      s = {a[7], a} + {b[7], b};
      return s[8] != s[7];
    end
    s = {1'b0, a} + {1'b0, b};
    return s[8];
  endfunction

  logic [LANES-1:0] lane_sat;
  logic [LANES-1:0] sat_q, sat_d;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_sat[i] = sat_hit(first_beat ? 8'h00 : acc_q[i],
                            {bus.in_hi[4*i +: 4], bus.in_lo[4*i +: 4]}, eff_sign);
    end
  end

  always_comb begin
    sat_d = sat_q;
    if (accept) begin
      sat_d = first_beat ? lane_sat : (sat_q | lane_sat);
    end else if (state_q == DRAIN1 && bus.out_ready) begin
      sat_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= '0;
    else        sat_q <= sat_d;
  end

  assign bus.sat_mask = sat_q;
`else
  assign bus.sat_mask = '0;
`endif

  // NOTE: next-state logic uses blocking assignments with a default for every target first,
  // so no path through the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    out_valid_d = out_valid_q;
    out_beat_d  = out_beat_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          acc_d  = sum_lane;
          sign_d = eff_sign;
          if (first_beat)             cnt_d = CNT_W'(1);
          else if (cnt_q != '1)       cnt_d = cnt_q + CNT_W'(1);
          if (bus.in_last) begin
            state_d     = DRAIN0;
            out_valid_d = 1'b1;
            out_beat_d  = 1'b0;
            out_data_d  = sum_lane[HALF-1:0];
          end else begin
            state_d = ACC;
          end
        end
      end
      DRAIN0: begin
        if (bus.out_ready) begin
          state_d    = DRAIN1;
          out_beat_d = 1'b1;
          out_data_d = acc_q[LANES-1:HALF];
        end
      end
      DRAIN1: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_beat_d  = 1'b0;
          out_data_d  = '0;
          acc_d       = '0;
          cnt_d       = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the accumulator array is reset (not just the state) because a reset mid-group
  // must discard the partial sums; sequential state is updated with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_beat_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      out_valid_q <= out_valid_d;
      out_beat_q  <= out_beat_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_beat  = out_beat_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_cnt   = cnt_q;
endmodule
